rob_alloc_ptr: RTL and testbench
================================

# rob_alloc_ptr

ROB allocation pointer unit in the ID stage, directly upstream of the front-end RAT. Tracks ROB head/tail and occupancy, assigns ROB IDs to up to ISSUE_WIDTH_MAX issuing instructions per cycle, and drives rob_is_ptr, rob_is_ptr_p1 and rob_full into the rename stage. Head advances on retirement; tail rewinds on a branch mispredict clear.

## Interface
- ISSUE_WIDTH_MAX, 2, instructions allocated per cycle
- ROB_MAX_RETIRE, 2, entries retired per cycle
- ROB_SIZE, 32, ROB entries, power of two
- ROB_SIZE_CLOG, 5, log2(ROB_SIZE)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- instr_val_id  in  ISSUE_WIDTH_MAX  valid instructions requesting allocation; any pattern allowed
- val_ret  in  ROB_MAX_RETIRE  retiring entries; must be LSB-contiguous
- branch_clear_id  in  1  mispredict flush
- mispredict_tag_id  in  ROB_SIZE_CLOG  ROB ID of the mispredicted branch; it and older entries survive
- rob_is_ptr  out  ROB_SIZE_CLOG  tail index
- rob_is_ptr_p1  out  ROB_SIZE_CLOG  tail+1 mod ROB_SIZE
- robid_is  out  ISSUE_WIDTH_MAX x ROB_SIZE_CLOG  ID per slot
- alloc_id  out  ISSUE_WIDTH_MAX  slot allocated this cycle
- rob_ret_ptr  out  ROB_SIZE_CLOG  head index, oldest entry
- rob_count  out  ROB_SIZE_CLOG+1  occupancy
- rob_full  out  1  free entries < ISSUE_WIDTH_MAX
- rob_empty  out  1  rob_count == 0
- rob_err  out  1  sticky protocol-violation flag

## Operation
- State: head, tail (ROB_SIZE_CLOG+1 bits each, MSB is wrap bit), count, err.
- Count invariant: count == tail - head, computed modulo 2*ROB_SIZE.
- Slot ID: robid_is[i] = tail + popcount(instr_val_id[i-1:0]), mod ROB_SIZE (compacted; slot 1 gets tail when slot 0 invalid).
- Allocation is all-or-nothing: alloc_id = instr_val_id & {rob_full==0 and branch_clear_id==0}. alloc_cnt = popcount(alloc_id).
- ret_cnt = popcount(val_ret).
- Retirement is legal only if val_ret is LSB-contiguous and ret_cnt <= count. Otherwise ret_cnt is forced to 0 and err sets.
- Normal cycle: head += ret_cnt; tail += alloc_cnt; count += alloc_cnt - ret_cnt.
- Flush cycle (branch_clear_id=1):
  - keep = ((mispredict_tag_id - head[low]) mod ROB_SIZE) + 1.
  - If keep > count, the tag is outside the live window: err sets and state holds.
  - Otherwise head += ret_cnt; count = keep - ret_cnt; tail = head_old + keep (wrap bit included).
  - Allocation is suppressed.
- Retirement of the branch itself in the flush cycle is legal and is covered by ret_cnt.
- err clears only on reset.

## Timing
- robid_is, alloc_id, rob_is_ptr, rob_is_ptr_p1 are combinational in the ID cycle. The first two depend on instr_val_id and branch_clear_id; the pointers depend on registered state only.
- rob_full, rob_empty, rob_count, rob_ret_ptr are derived from registered state only (no input-to-output path).
- Pointer updates take effect on the next clk; zero-bubble back-to-back allocation.
- Reset (asserted asynchronously, any cycle, including mid-flush) forces:
  - head=tail=0, count=0, rob_is_ptr=0, rob_is_ptr_p1=1, rob_ret_ptr=0, rob_full=0, rob_empty=1, rob_err=0.
- Wrap-around: index 31 + 1 -> 0 with the wrap bit toggling. Full/empty are never confused because count carries the extra bit.
- Simultaneous allocate and retire when rob_full=1: retire proceeds, allocation is refused. rob_full deasserts the next cycle if space frees.

## Structure
- ROB_SIZE, ROB_SIZE_CLOG, ISSUE_WIDTH_MAX, ROB_MAX_RETIRE stay in rtl_constants.sv.
- A typedef rob_ptr_t (ROB_SIZE_CLOG+1 bits, wrap + index) is added to the shared package for reuse by the ROB.
- One sub-module: prefix_popcnt (parameterised width; outputs per-bit exclusive prefix counts and total). Instantiated for instr_val_id and val_ret.

## Test plan
- Reset, then instr_val_id=2'b11 for 3 cycles -> robid_is {0,1},{2,3},{4,5}; count=6; rob_is_ptr=6.
- instr_val_id=2'b10 at tail=7 -> robid_is[1]=7, alloc_id=2'b10, next tail=8.
- Fill to count=31 -> rob_full=1, instr_val_id=2'b01 refused; same cycle val_ret=2'b11 -> count=29, next cycle rob_full=0.
- Wrap case: head=30, tail=30, allocate 2 x 2 -> IDs 30,31,0,1; rob_is_ptr=2, count=4, rob_empty=0.
- Flush: head=4, count=10, mispredict_tag_id=6, val_ret=2'b01 -> head=5, count=2, tail=7; allocation in that cycle suppressed.
- Illegal val_ret=2'b10 -> head unchanged, rob_err=1 and stays 1; assert rst_n mid-run -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/rob_alloc_ptr_pkg.sv
// Shared ROB sizing constants and pointer types for the allocation unit and the ROB.
// Pointers carry an extra wrap bit above the index so full and empty stay distinct.
package rob_alloc_ptr_pkg;

   localparam int ISSUE_WIDTH_MAX = 2;
   localparam int ROB_MAX_RETIRE  = 2;
   localparam int ROB_SIZE        = 32;
   localparam int ROB_SIZE_CLOG   = 5;

   localparam int ISS_CNT_W   = $clog2(ISSUE_WIDTH_MAX + 1);
   localparam int RET_CNT_W   = $clog2(ROB_MAX_RETIRE + 1);
   localparam int FULL_THRESH = ROB_SIZE - ISSUE_WIDTH_MAX;

   typedef logic [ROB_SIZE_CLOG:0]   rob_ptr_t;
   typedef logic [ROB_SIZE_CLOG-1:0] rob_id_t;
   typedef logic [ROB_SIZE_CLOG:0]   rob_cnt_t;

   function automatic rob_id_t ptr_idx(input rob_ptr_t p);
      return p[ROB_SIZE_CLOG-1:0];
   endfunction

endpackage

// File: rtl/rob_alloc_ptr_if.sv
// ID-stage allocation bundle between the decode/rename side and the ROB pointer unit.
// Requests flow in on master outputs; IDs, pointers and status flow back on slave outputs.
interface rob_alloc_ptr_if;
   import rob_alloc_ptr_pkg::*;

   logic    [ISSUE_WIDTH_MAX-1:0]          instr_val_id;
   logic    [ROB_MAX_RETIRE-1:0]           val_ret;
   logic                                   branch_clear_id;
   rob_id_t                                mispredict_tag_id;
   rob_id_t                                rob_is_ptr;
   rob_id_t                                rob_is_ptr_p1;
   rob_id_t [ISSUE_WIDTH_MAX-1:0]          robid_is;
   logic    [ISSUE_WIDTH_MAX-1:0]          alloc_id;
   rob_id_t                                rob_ret_ptr;
   rob_cnt_t                               rob_count;
   logic                                   rob_full;
   logic                                   rob_empty;
   logic                                   rob_err;

   modport master (
      output instr_val_id, val_ret, branch_clear_id, mispredict_tag_id,
      input  rob_is_ptr, rob_is_ptr_p1, robid_is, alloc_id,
      input  rob_ret_ptr, rob_count, rob_full, rob_empty, rob_err
   );

   modport slave (
      input  instr_val_id, val_ret, branch_clear_id, mispredict_tag_id,
      output rob_is_ptr, rob_is_ptr_p1, robid_is, alloc_id,
      output rob_ret_ptr, rob_count, rob_full, rob_empty, rob_err
   );

endinterface

// File: rtl/rob_alloc_ptr_prefix_popcnt.sv
// Exclusive prefix popcount per bit plus total; purely combinational, no backpressure.
module prefix_popcnt #(
   parameter int WIDTH = 2,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0]            vec,
   output logic [WIDTH-1:0][CNT_W-1:0] pre,
   output logic [CNT_W-1:0]            total
);

   logic [CNT_W-1:0] acc;

   always_comb begin
      acc = '0;
      pre = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pre[i] = acc;
         acc    = acc + CNT_W'(vec[i]);
      end
      total = acc;
   end

endmodule

// File: rtl/rob_alloc_ptr.sv
// ROB head/tail/occupancy tracker: IDs and alloc grants are combinational, state updates next clk.
// Backpressure: whole-group allocation refused while fewer than ISSUE_WIDTH_MAX entries are free or on flush.
module rob_alloc_ptr
   import rob_alloc_ptr_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   rob_alloc_ptr_if.slave  rob
);

   rob_ptr_t head_q, head_d;
   rob_ptr_t tail_q, tail_d;
   rob_cnt_t count_q, count_d;
   logic     err_q, err_d;

   logic [ISSUE_WIDTH_MAX-1:0][ISS_CNT_W-1:0] iss_pre;
   logic [ISS_CNT_W-1:0]                      iss_total;
   logic [ROB_MAX_RETIRE-1:0][RET_CNT_W-1:0]  ret_pre;
   logic [RET_CNT_W-1:0]                      ret_total;

   logic                 full;
   logic                 alloc_ok;
   logic [ISS_CNT_W-1:0] alloc_cnt;
   logic                 ret_contig;
   logic                 ret_ok;
   logic [RET_CNT_W-1:0] ret_eff;
   rob_cnt_t             keep;
   logic                 flush_bad;

   prefix_popcnt #(.WIDTH(ISSUE_WIDTH_MAX), .CNT_W(ISS_CNT_W)) u_iss_cnt (
      .vec   (rob.instr_val_id),
      .pre   (iss_pre),
      .total (iss_total)
   );

   prefix_popcnt #(.WIDTH(ROB_MAX_RETIRE), .CNT_W(RET_CNT_W)) u_ret_cnt (
      .vec   (rob.val_ret),
      .pre   (ret_pre),
      .total (ret_total)
   );

   assign full      = count_q > rob_cnt_t'(FULL_THRESH);
   assign alloc_ok  = !full && !rob.branch_clear_id;
   assign alloc_cnt = alloc_ok ? iss_total : '0;

   // A set retire bit is contiguous only if every lower bit is set too.
   always_comb begin
      ret_contig = 1'b1;
      for (int i = 0; i < ROB_MAX_RETIRE; i++) begin
         if (rob.val_ret[i] && (ret_pre[i] != RET_CNT_W'(i))) ret_contig = 1'b0;
      end
   end

   assign ret_ok    = ret_contig && (rob_cnt_t'(ret_total) <= count_q);
   assign ret_eff   = ret_ok ? ret_total : '0;
   assign keep      = rob_cnt_t'(rob_id_t'(rob.mispredict_tag_id - ptr_idx(head_q))) + rob_cnt_t'(1);
   assign flush_bad = rob.branch_clear_id && (keep > count_q);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = err_q | ~ret_ok | flush_bad;
      if (rob.branch_clear_id) begin
         if (!flush_bad) begin
            head_d  = head_q + rob_ptr_t'(ret_eff);
            tail_d  = head_q + rob_ptr_t'(keep);
            count_d = keep - rob_cnt_t'(ret_eff);
         end
      end else begin
         head_d  = head_q + rob_ptr_t'(ret_eff);
         tail_d  = tail_q + rob_ptr_t'(alloc_cnt);
         count_d = count_q + rob_cnt_t'(alloc_cnt) - rob_cnt_t'(ret_eff);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Slot IDs are compacted over valid requests, independent of the grant.
   always_comb begin
      rob.robid_is = '0;
      for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
         rob.robid_is[i] = ptr_idx(tail_q) + rob_id_t'(iss_pre[i]);
      end
   end

   assign rob.alloc_id      = rob.instr_val_id & {ISSUE_WIDTH_MAX{alloc_ok}};
   assign rob.rob_is_ptr    = ptr_idx(tail_q);
   assign rob.rob_is_ptr_p1 = ptr_idx(tail_q) + rob_id_t'(1);
   assign rob.rob_ret_ptr   = ptr_idx(head_q);
   assign rob.rob_count     = count_q;
   assign rob.rob_full      = full;
   assign rob.rob_empty     = (count_q == '0);
   assign rob.rob_err       = err_q;

endmodule

// File: tb/tb_rob_alloc_ptr.sv
// Bench for rob_alloc_ptr: directed vector table, corner sequences, and random traffic vs an absolute-count model.
module tb_rob_alloc_ptr;
   import rob_alloc_ptr_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rob_alloc_ptr_if rif();
   rob_alloc_ptr dut (.clk(clk), .rst_n(rst_n), .rob(rif.slave));

   int n_chk  = 0;
   int n_fail = 0;

   // Model: head/tail are total entries ever retired/allocated, never wrapped.
   int m_head, m_tail;
   bit m_err;

   typedef struct {
      logic [1:0] iv;
      logic [1:0] vr;
      logic [4:0] id0, id1;
      logic [1:0] alloc;
      logic [4:0] ptr, ret;
      logic [5:0] cnt;
      logic       full, empty, err;
   } vec_t;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_head = 0;
      m_tail = 0;
      m_err  = 1'b0;
   endfunction

   function automatic void check_model();
      int cnt;
      bit full_e;
      logic [1:0] al;
      cnt    = m_tail - m_head;
      full_e = (ROB_SIZE - cnt) < ISSUE_WIDTH_MAX;
      al     = (full_e || rif.branch_clear_id) ? 2'b00 : rif.instr_val_id;
      chk("rob_count", rif.rob_count, cnt);
      chk("rob_is_ptr", rif.rob_is_ptr, m_tail % ROB_SIZE);
      chk("rob_is_ptr_p1", rif.rob_is_ptr_p1, (m_tail + 1) % ROB_SIZE);
      chk("rob_ret_ptr", rif.rob_ret_ptr, m_head % ROB_SIZE);
      chk("rob_full", rif.rob_full, full_e);
      chk("rob_empty", rif.rob_empty, cnt == 0);
      chk("rob_err", rif.rob_err, m_err);
      chk("alloc_id", rif.alloc_id, al);
      chk("robid_is0", rif.robid_is[0], m_tail % ROB_SIZE);
      chk("robid_is1", rif.robid_is[1], (m_tail + rif.instr_val_id[0]) % ROB_SIZE);
   endfunction

   function automatic void model_step();
      int cnt, rc, keep, nt;
      bit full_e, legal;
      cnt    = m_tail - m_head;
      full_e = (ROB_SIZE - cnt) < ISSUE_WIDTH_MAX;
      rc     = $countones(rif.val_ret);
      legal  = (rif.val_ret == 2'b00 || rif.val_ret == 2'b01 || rif.val_ret == 2'b11) && rc <= cnt;
      if (!legal) begin
         rc    = 0;
         m_err = 1'b1;
      end
      if (rif.branch_clear_id) begin
         keep = ((int'(rif.mispredict_tag_id) - (m_head % ROB_SIZE) + ROB_SIZE) % ROB_SIZE) + 1;
         if (keep > cnt) begin
            m_err = 1'b1;
         end else begin
            nt     = m_head + keep;
            m_head = m_head + rc;
            m_tail = nt;
         end
      end else begin
         m_head = m_head + rc;
         if (!full_e) m_tail = m_tail + $countones(rif.instr_val_id);
      end
   endfunction

   task automatic drive(input logic [1:0] iv, input logic [1:0] vr, input logic bc, input logic [4:0] tag);
      @(negedge clk);
      rif.instr_val_id      = iv;
      rif.val_ret           = vr;
      rif.branch_clear_id   = bc;
      rif.mispredict_tag_id = tag;
      #1;
      check_model();
   endtask

   task automatic cycle(input logic [1:0] iv, input logic [1:0] vr, input logic bc, input logic [4:0] tag);
      drive(iv, vr, bc, tag);
      model_step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rif.instr_val_id      = '0;
      rif.val_ret           = '0;
      rif.branch_clear_id   = 1'b0;
      rif.mispredict_tag_id = '0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t vecs[8];

   initial begin
      int cnt;
      logic [1:0] vr;
      logic bc;
      logic [4:0] tag;

      rif.instr_val_id      = '0;
      rif.val_ret           = '0;
      rif.branch_clear_id   = 1'b0;
      rif.mispredict_tag_id = '0;
      model_reset();

      //          iv     vr     id0 id1 alloc  ptr ret cnt full empty err
      vecs[0] = '{2'b11, 2'b00, 0,  1,  2'b11, 0,  0,  0,  0,   1,    0};
      vecs[1] = '{2'b11, 2'b00, 2,  3,  2'b11, 2,  0,  2,  0,   0,    0};
      vecs[2] = '{2'b11, 2'b00, 4,  5,  2'b11, 4,  0,  4,  0,   0,    0};
      vecs[3] = '{2'b01, 2'b00, 6,  7,  2'b01, 6,  0,  6,  0,   0,    0};
      vecs[4] = '{2'b10, 2'b00, 7,  7,  2'b10, 7,  0,  7,  0,   0,    0};
      vecs[5] = '{2'b00, 2'b00, 8,  8,  2'b00, 8,  0,  8,  0,   0,    0};
      vecs[6] = '{2'b00, 2'b01, 8,  8,  2'b00, 8,  0,  8,  0,   0,    0};
      vecs[7] = '{2'b00, 2'b00, 8,  8,  2'b00, 8,  1,  7,  0,   0,    0};

      do_reset();
      // Reset values
      chk("rst_ptr", rif.rob_is_ptr, 0);
      chk("rst_ptr_p1", rif.rob_is_ptr_p1, 1);
      chk("rst_empty", rif.rob_empty, 1);

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].iv, vecs[i].vr, 1'b0, 5'd0);
         chk("v_id0", rif.robid_is[0], vecs[i].id0);
         chk("v_id1", rif.robid_is[1], vecs[i].id1);
         chk("v_alloc", rif.alloc_id, vecs[i].alloc);
         chk("v_ptr", rif.rob_is_ptr, vecs[i].ptr);
         chk("v_ret", rif.rob_ret_ptr, vecs[i].ret);
         chk("v_cnt", rif.rob_count, vecs[i].cnt);
         chk("v_full", rif.rob_full, vecs[i].full);
         chk("v_empty", rif.rob_empty, vecs[i].empty);
         chk("v_err", rif.rob_err, vecs[i].err);
         model_step();
      end

      // Fill to 31, then refused allocate with simultaneous double retire
      for (int i = 0; i < 12; i++) cycle(2'b11, 2'b00, 1'b0, 5'd0);
      drive(2'b01, 2'b11, 1'b0, 5'd0);
      chk("full_cnt", rif.rob_count, 31);
      chk("full_flag", rif.rob_full, 1);
      chk("full_refuse", rif.alloc_id, 0);
      model_step();
      drive(2'b00, 2'b00, 1'b0, 5'd0);
      chk("after_full_cnt", rif.rob_count, 29);
      chk("after_full_flag", rif.rob_full, 0);
      model_step();

      // Wrap: head=tail=30, two double allocations
      do_reset();
      for (int i = 0; i < 15; i++) cycle(2'b11, 2'b00, 1'b0, 5'd0);
      for (int i = 0; i < 15; i++) cycle(2'b00, 2'b11, 1'b0, 5'd0);
      drive(2'b11, 2'b00, 1'b0, 5'd0);
      chk("wrap_id0a", rif.robid_is[0], 30);
      chk("wrap_id1a", rif.robid_is[1], 31);
      model_step();
      drive(2'b11, 2'b00, 1'b0, 5'd0);
      chk("wrap_id0b", rif.robid_is[0], 0);
      chk("wrap_id1b", rif.robid_is[1], 1);
      model_step();
      drive(2'b00, 2'b00, 1'b0, 5'd0);
      chk("wrap_ptr", rif.rob_is_ptr, 2);
      chk("wrap_cnt", rif.rob_count, 4);
      chk("wrap_empty", rif.rob_empty, 0);
      model_step();

      // Flush with retire: head=4 count=10 tag=6
      do_reset();
      for (int i = 0; i < 7; i++) cycle(2'b11, 2'b00, 1'b0, 5'd0);
      for (int i = 0; i < 2; i++) cycle(2'b00, 2'b11, 1'b0, 5'd0);
      drive(2'b11, 2'b01, 1'b1, 5'd6);
      chk("flush_alloc", rif.alloc_id, 0);
      model_step();
      drive(2'b00, 2'b00, 1'b0, 5'd0);
      chk("flush_head", rif.rob_ret_ptr, 5);
      chk("flush_cnt", rif.rob_count, 2);
      chk("flush_tail", rif.rob_is_ptr, 7);
      model_step();

      // Illegal retire pattern, sticky err, then asynchronous reset mid-cycle
      drive(2'b00, 2'b10, 1'b0, 5'd0);
      model_step();
      drive(2'b00, 2'b00, 1'b0, 5'd0);
      chk("ill_err", rif.rob_err, 1);
      chk("ill_head", rif.rob_ret_ptr, 5);
      model_step();
      cycle(2'b11, 2'b00, 1'b0, 5'd0);
      chk("ill_sticky", rif.rob_err, 1);
      rif.instr_val_id = 2'b00;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ptr", rif.rob_is_ptr, 0);
      chk("arst_p1", rif.rob_is_ptr_p1, 1);
      chk("arst_ret", rif.rob_ret_ptr, 0);
      chk("arst_cnt", rif.rob_count, 0);
      chk("arst_full", rif.rob_full, 0);
      chk("arst_empty", rif.rob_empty, 1);
      chk("arst_err", rif.rob_err, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Flush tag outside live window
      for (int i = 0; i < 2; i++) cycle(2'b11, 2'b00, 1'b0, 5'd0);
      cycle(2'b00, 2'b00, 1'b1, 5'd10);
      drive(2'b00, 2'b00, 1'b0, 5'd0);
      chk("oow_err", rif.rob_err, 1);
      chk("oow_cnt", rif.rob_count, 4);
      model_step();

      // Random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 499) do_reset();
         cnt = m_tail - m_head;
         if ((i / 150) % 2 == 0) vr = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
         else begin
            case ($urandom_range(0, 2))
               0: vr = 2'b00;
               1: vr = 2'b01;
               default: vr = 2'b11;
            endcase
         end
         if ($urandom_range(0, 59) == 0) vr = 2'b10;
         bc  = ($urandom_range(0, 11) == 0);
         tag = (cnt > 0) ? 5'((m_head + $urandom_range(0, cnt - 1)) % ROB_SIZE) : 5'd0;
         if ($urandom_range(0, 3) == 0) tag = 5'($urandom_range(0, 31));
         if (bc && vr != 2'b00) vr = 2'b01;
         cycle(2'($urandom_range(0, 3)), vr, bc, tag);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
